nand_truth_table_engine: RTL
============================

Name: nand_truth_table_engine

Overview:
- Parametrised, clocked successor to the team's 2-input NAND-built gate blocks.
- Sweeps all 2^N_IN input combinations through a mode-selected N_IN-input function built only from 2-input NAND primitives.
- Streams each row and collects the full truth-table column into a result vector.
- Used as a self-checking truth-table generator for the gate exercises.

Parameters:
- N_IN, 2, number of function inputs; legal range 1..4.
- ROWS, 2**N_IN, derived row count; not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
- mode  input  3  function select, sampled with start: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 BUF a[0], 7 NOT a[0].
- busy  output  1  high in SWEEP and DONE.
- row_valid  output  1  high for each streamed row.
- row_in  output  N_IN  input combination of the current row (row index).
- row_out  output  1  function result for row_in.
- table_out  output  ROWS  bit k = f(k); held after the sweep.
- done  output  1  one-cycle pulse after the last row.

Behaviour:
- Reset (rst=1 at clk edge) forces state to IDLE and sets busy, row_valid, row_in, row_out, table_out, done and the latched mode all to 0.
- Reset mid-sweep aborts the sweep with no done pulse.
- The function core is combinational over row index idx.
  - Reductions over all N_IN bits are cascaded 2-input NANDs.
  - AND = NAND followed by a NAND used as an inverter.
  - OR = NAND of the inverted inputs.
  - XOR = standard 4-NAND cell chained across the bits (parity).
  - BUF/NOT use idx[0] only.
  - For N_IN=1, AND/OR/XOR all reduce to a[0].
- IDLE:
  - outputs row_valid=0 and done=0; table_out holds its last value.
  - start=1 latches mode, clears table_out to 0, sets idx=0 and moves to SWEEP.
- SWEEP (one row per cycle):
  - row_valid=1, row_in=idx, row_out=f(idx).
  - At the same edge table_out[idx] <= f(idx), as seen from the next cycle.
  - If idx==ROWS-1, move to DONE; otherwise idx increments.
  - idx never wraps inside a sweep.
- DONE: done=1 and row_valid=0 for exactly one cycle, then IDLE.
- Timing: start sampled at edge 0 gives the first row valid after edge 1 and the last row after edge ROWS. done is high after edge ROWS+1, and busy falls after edge ROWS+2.
- start is ignored in SWEEP and DONE. A mode change mid-sweep has no effect.
- start asserted in the same cycle that done is high is ignored. A new sweep needs start in IDLE.
- start held high continuously re-triggers each time IDLE is reached.
- rst has priority over start when both are high at the same edge.
- Illegal N_IN (0 or >4) must fail elaboration.

Optional Feature:
- Macro: TRUTH_COUNT_EN.
- Defined:
  - adds output ones_count, width N_IN+1: the number of rows with f=1 in the current or last sweep.
  - Cleared by rst and by an accepted start; increments in SWEEP when row_out=1; holds after DONE.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- N_IN=2, mode=0 (AND), start pulse -> rows (00,0)(01,0)(10,0)(11,1); table_out=4'b1000; done one cycle after row 3, i.e. 5 edges after start; ones_count=1 if enabled.
- N_IN=2, mode=1 then mode=3 in separate sweeps -> table_out=4'b1110 then 4'b0001; table_out cleared to 0 in the first SWEEP cycle of the second sweep.
- N_IN=3, mode=4 (XOR) -> table_out=8'b10010110; mode=5 -> 8'b01101001; ones_count=4 for both.
- N_IN=2, mode=7 (NOT) with mode driven to 0 during the sweep, plus a start pulse at row 1 -> table_out=4'b0101, a single done pulse, no restart.
- rst asserted during row 2 of an N_IN=3 sweep -> next cycle all outputs 0, IDLE, no done; a following start gives a full clean sweep.
- N_IN=1, mode=6 -> table_out=2'b10, done 3 edges after start; with TRUTH_COUNT_EN undefined the bench compiles without ones_count.

Source files
------------

// File: rtl/nand_truth_table_engine.sv
// nand_truth_table_engine
// Sweeps every input combination of an N_IN-input function and streams one row
// per clock. The function is built only from 2-input NAND primitives. The full
// truth-table column is collected into table_out.
// Optional feature macro: TRUTH_COUNT_EN adds the ones_count output, which
// counts the rows with f=1 in the current or most recent sweep.
module nand_truth_table_engine #(
    parameter int N_IN = 2,
    parameter int ROWS = 2 ** N_IN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        mode,
    output logic              busy,
    output logic              row_valid,
    output logic [N_IN-1:0]   row_in,
    output logic              row_out,
    output logic [ROWS-1:0]   table_out,
`ifdef TRUTH_COUNT_EN
    output logic              done,
    output logic [N_IN:0]     ones_count
`else
    output logic              done
`endif
);

    // Elaboration guards: the row index and table width only make sense here.
    if (N_IN < 1 || N_IN > 4) begin : g_bad_n_in
        $fatal(1, "nand_truth_table_engine: N_IN must be in 1..4");
    end
    if (ROWS != 2 ** N_IN) begin : g_bad_rows
        $fatal(1, "nand_truth_table_engine: ROWS is derived and must equal 2**N_IN");
    end

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SWEEP = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [N_IN-1:0] LAST_ROW = N_IN'(ROWS - 1);

    logic [1:0]      state;
    logic [N_IN-1:0] idx;
    logic [2:0]      mode_q;
    logic            f_row;
    logic            accept;

    function automatic logic nand2(input logic a, input logic b);
        return ~(a & b);
    endfunction

    function automatic logic inv(input logic a);
        return nand2(a, a);
    endfunction

    // Every reduction is a chain of 2-input NAND cells, widened one bit at a time.
    function automatic logic eval_fn(input logic [2:0] m, input logic [N_IN-1:0] a);
        logic and_r;
        logic or_r;
        logic xor_r;
        logic t;
        logic r;
        and_r = a[0];
        or_r  = a[0];
        xor_r = a[0];
        t     = 1'b0;
        for (int i = 1; i < N_IN; i++) begin
            // AND: NAND followed by a NAND wired as an inverter
            and_r = inv(nand2(and_r, a[i]));
            // OR: NAND of the inverted inputs
            or_r  = nand2(inv(or_r), inv(a[i]));
            // XOR: the classic 4-NAND cell, chained for parity
            t     = nand2(xor_r, a[i]);
            xor_r = nand2(nand2(xor_r, t), nand2(a[i], t));
        end
        case (m)
            3'd0:    r = and_r;
            3'd1:    r = or_r;
            3'd2:    r = inv(and_r);
            3'd3:    r = inv(or_r);
            3'd4:    r = xor_r;
            3'd5:    r = inv(xor_r);
            3'd6:    r = a[0];
            default: r = inv(a[0]);
        endcase
        return r;
    endfunction

    // Function core evaluated on the current row index with the latched mode.
    always_comb begin
        f_row = eval_fn(mode_q, idx);
    end

    // A start in the cycle done is visible still belongs to the finishing sweep.
    assign accept = (state == S_IDLE) && start && !done;

    // Sweep sequencer: drives the row stream, builds the table and pulses done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            mode_q    <= '0;
            busy      <= 1'b0;
            row_valid <= 1'b0;
            row_in    <= '0;
            row_out   <= 1'b0;
            table_out <= '0;
            done      <= 1'b0;
        end else begin
            busy      <= accept || (state != S_IDLE);
            row_valid <= (state == S_SWEEP);
            done      <= (state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        mode_q    <= mode;
                        table_out <= '0;
                        idx       <= '0;
                        state     <= S_SWEEP;
                    end
                end
                S_SWEEP: begin
                    row_in         <= idx;
                    row_out        <= f_row;
                    table_out[idx] <= f_row;
                    if (idx == LAST_ROW) begin
                        state <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef TRUTH_COUNT_EN
    // Ones counter: restarts with each accepted sweep and holds after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ones_count <= '0;
        end else if (accept) begin
            ones_count <= '0;
        end else if (state == S_SWEEP && f_row) begin
            ones_count <= ones_count + 1'b1;
        end
    end
`endif

endmodule
